// File: rtl/sipo_pkg.sv
// Shared constants and state encoding for the serial-in/parallel-out deserializer.
// Bit-order selectors and the two-state word-assembly FSM encoding live here.
package sipo_pkg;

  localparam logic DIR_LSB_FIRST = 1'b0;
  localparam logic DIR_MSB_FIRST = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sipo_shift_core.sv
// Word-assembly core: shift register, bit counter, per-word direction latch and FSM.
// Presents the completed word combinationally with a one-cycle word_done pulse.
module sipo_shift_core
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  input  logic             dir,
  output logic [WIDTH-1:0] word,
  output logic             word_done,
  output logic [CNT_W-1:0] bit_cnt,
  output state_t           state
);

  state_t           state_nx;
  logic [WIDTH-1:0] sr, sr_nx, shifted;
  logic [CNT_W-1:0] cnt_nx;
  logic             word_dir, word_dir_nx;
  logic             start;
  logic             use_dir;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sr       <= '0;
      bit_cnt  <= '0;
      word_dir <= DIR_LSB_FIRST;
    end else begin
      state    <= state_nx;
      sr       <= sr_nx;
      bit_cnt  <= cnt_nx;
      word_dir <= word_dir_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    sr_nx       = sr;
    cnt_nx      = bit_cnt;
    word_dir_nx = word_dir;
    word_done   = 1'b0;

    // A new word begins either from IDLE or on a resync strobe; the first bit
    // must already use the freshly sampled dir, not the stale latched one.
    start   = ser_valid & (frame_start | (state == ST_IDLE));
    use_dir = start ? dir : word_dir;
    shifted = (use_dir == DIR_MSB_FIRST) ? {sr[WIDTH-2:0], ser_in}
                                         : {ser_in, sr[WIDTH-1:1]};
    word    = shifted;

    if (ser_valid) begin
      sr_nx = shifted;
      if (start) begin
        state_nx    = ST_SHIFT;
        cnt_nx      = CNT_W'(1);
        word_dir_nx = dir;
      end else if (bit_cnt == CNT_W'(WIDTH - 1)) begin
        state_nx  = ST_IDLE;
        cnt_nx    = '0;
        word_done = 1'b1;
      end else begin
        cnt_nx = bit_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words and hands them off through a
// single-entry holding register with a sticky overrun flag for words that found it full.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             frame_start,
  input  logic             dir,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  input  logic             par_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  input  logic             clr_overrun
);

  logic [WIDTH-1:0] word;
  logic             word_done;
  state_t           core_state;
  logic             accept;
  logic             load;
  logic             drop;

  sipo_shift_core #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .frame_start(frame_start),
    .dir        (dir),
    .word       (word),
    .word_done  (word_done),
    .bit_cnt    (bit_cnt),
    .state      (core_state)
  );

  assign busy = (core_state == ST_SHIFT);

  // Handshake: a word transfers on any cycle where par_valid & par_ready are both high.
  // par_out is held stable while par_valid is high until that transfer occurs; a word
  // completing in the transfer cycle takes the slot directly, so there is no bubble.
  assign accept = par_valid & par_ready;
  assign load   = word_done & (~par_valid | par_ready);
  assign drop   = word_done & par_valid & ~par_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_out   <= '0;
      par_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        par_out   <= word;
        par_valid <= 1'b1;
      end else if (accept) begin
        par_valid <= 1'b0;
      end
      // A fresh drop outranks a simultaneous clear so no lost word goes unreported.
      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Bench for sipo_deserializer (WIDTH=4): directed scenarios plus a randomized run,
// all checked against a bit-list reference model of word assembly and handoff.
module tb_sipo_deserializer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ser_in = 1'b0;
  logic             ser_valid = 1'b0;
  logic             frame_start = 1'b0;
  logic             dir = 1'b0;
  logic [WIDTH-1:0] par_out;
  logic             par_valid;
  logic             par_ready = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;
  logic             clr_overrun = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the word in progress is a list of received bits.
  bit               m_bits[$];
  logic             m_dir;
  logic [WIDTH-1:0] m_po;
  logic             m_pv;
  logic             m_ovr;
  logic [WIDTH-1:0] exp_q[$];

  sipo_deserializer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .frame_start(frame_start),
    .dir        (dir),
    .par_out    (par_out),
    .par_valid  (par_valid),
    .par_ready  (par_ready),
    .busy       (busy),
    .bit_cnt    (bit_cnt),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  // One clock: the model consumes the same inputs the DUT samples at this edge.
  task automatic step();
    logic             done;
    logic [WIDTH-1:0] w;
    @(posedge clk);
    done = 1'b0;
    w    = '0;
    if (rst) begin
      m_bits.delete();
      m_dir = 1'b0;
      m_po  = '0;
      m_pv  = 1'b0;
      m_ovr = 1'b0;
      exp_q.delete();
    end else begin
      if (ser_valid) begin
        if (frame_start || m_bits.size() == 0) begin
          m_bits.delete();
          m_dir = dir;
        end
        m_bits.push_back(ser_in);
        if (m_bits.size() == WIDTH) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (m_dir) w[WIDTH-1-i] = m_bits[i];
            else       w[i]         = m_bits[i];
          end
          m_bits.delete();
          done = 1'b1;
        end
      end
      if (done && m_pv && !par_ready) begin
        m_ovr = 1'b1;
      end else begin
        if (done) begin
          m_po = w;
          m_pv = 1'b1;
          exp_q.push_back(w);
        end else if (m_pv && par_ready) begin
          m_pv = 1'b0;
        end
        if (clr_overrun) m_ovr = 1'b0;
      end
    end
    #1;
  endtask

  task automatic send_bit(input logic b, input logic fs);
    ser_in      = b;
    ser_valid   = 1'b1;
    frame_start = fs;
    step();
    ser_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] bits_first_to_last);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(bits_first_to_last[i], 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++; if (par_out !== 4'b0000) begin n_fail++; $display("FAIL reset_par_out: got %b exp 0000", par_out); end
    n_checks++; if (par_valid !== 1'b0) begin n_fail++; $display("FAIL reset_par_valid: got %b exp 0", par_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
    n_checks++; if (bit_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_bit_cnt: got %0d exp 0", bit_cnt); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
  endtask

  task automatic test_msb_first();
    dir = 1'b1;
    par_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    n_checks++; if ({par_valid, busy, bit_cnt} !== {1'b0, 1'b1, 2'd3}) begin n_fail++; $display("FAIL msb_partial: got pv=%b busy=%b cnt=%0d exp pv=0 busy=1 cnt=3", par_valid, busy, bit_cnt); end
    send_bit(1'b1, 1'b0);
    n_checks++; if (par_out !== 4'b1011) begin n_fail++; $display("FAIL msb_word: got %b exp 1011", par_out); end
    n_checks++; if ({par_valid, busy, bit_cnt} !== {1'b1, 1'b0, 2'd0}) begin n_fail++; $display("FAIL msb_done: got pv=%b busy=%b cnt=%0d exp pv=1 busy=0 cnt=0", par_valid, busy, bit_cnt); end
    step();
    n_checks++; if (par_valid !== 1'b0) begin n_fail++; $display("FAIL msb_accept: got pv=%b exp 0", par_valid); end
  endtask

  task automatic test_lsb_dir_toggle();
    dir = 1'b0;
    par_ready = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    dir = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    n_checks++; if ({par_valid, par_out} !== {1'b1, 4'b1101}) begin n_fail++; $display("FAIL lsb_word: got pv=%b %b exp pv=1 1101", par_valid, par_out); end
    par_ready = 1'b1;
    step();
    n_checks++; if (par_valid !== 1'b0) begin n_fail++; $display("FAIL lsb_accept: got pv=%b exp 0", par_valid); end
  endtask

  task automatic test_overrun();
    dir = 1'b1;
    par_ready = 1'b0;
    send_word(4'b1011);
    send_word(4'b0110);
    n_checks++; if ({par_valid, par_out, overrun} !== {1'b1, 4'b1011, 1'b1}) begin n_fail++; $display("FAIL overrun_hold: got pv=%b %b ovr=%b exp pv=1 1011 ovr=1", par_valid, par_out, overrun); end
    par_ready = 1'b1;
    step();
    n_checks++; if ({par_valid, par_out} !== {1'b0, 4'b1011}) begin n_fail++; $display("FAIL overrun_accept: got pv=%b %b exp pv=0 1011", par_valid, par_out); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b exp 1", overrun); end
    clr_overrun = 1'b1;
    step();
    clr_overrun = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: got %b exp 0", overrun); end
  endtask

  task automatic test_frame_start();
    dir = 1'b1;
    par_ready = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    n_checks++; if (bit_cnt !== 2'd2) begin n_fail++; $display("FAIL fs_no_valid: got cnt=%0d exp 2", bit_cnt); end
    send_bit(1'b0, 1'b1);
    n_checks++; if ({busy, bit_cnt} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL fs_resync: got busy=%b cnt=%0d exp busy=1 cnt=1", busy, bit_cnt); end
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    n_checks++; if ({par_valid, par_out, overrun} !== {1'b1, 4'b0010, 1'b0}) begin n_fail++; $display("FAIL fs_word: got pv=%b %b ovr=%b exp pv=1 0010 ovr=0", par_valid, par_out, overrun); end
    par_ready = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    dir = 1'b1;
    par_ready = 1'b0;
    send_word(4'b1010);
    send_bit(1'b0, 1'b0);
    ser_valid = 1'b0;
    step();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    n_checks++; if ({par_valid, par_out} !== {1'b1, 4'b1010}) begin n_fail++; $display("FAIL b2b_first: got pv=%b %b exp pv=1 1010", par_valid, par_out); end
    par_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    n_checks++; if ({par_valid, par_out, overrun} !== {1'b1, 4'b0101, 1'b0}) begin n_fail++; $display("FAIL b2b_second: got pv=%b %b ovr=%b exp pv=1 0101 ovr=0", par_valid, par_out, overrun); end
    step();
  endtask

  task automatic test_reset_mid();
    dir = 1'b1;
    par_ready = 1'b0;
    send_word(4'b1011);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if ({par_out, par_valid, busy, bit_cnt, overrun} !== 9'd0) begin n_fail++; $display("FAIL rst_mid: got po=%b pv=%b busy=%b cnt=%0d ovr=%b exp all 0", par_out, par_valid, busy, bit_cnt, overrun); end
    send_word(4'b1001);
    n_checks++; if ({par_valid, par_out} !== {1'b1, 4'b1001}) begin n_fail++; $display("FAIL rst_clean_word: got pv=%b %b exp pv=1 1001", par_valid, par_out); end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] exp_w;
    logic [8:0]       exp_vec;
    exp_q.delete();
    if (m_pv) exp_q.push_back(m_po);
    for (int i = 0; i < 600; i++) begin
      ser_in      = 1'($urandom_range(0, 1));
      ser_valid   = ($urandom_range(0, 9) < 7);
      frame_start = ($urandom_range(0, 19) == 0);
      dir         = 1'($urandom_range(0, 1));
      par_ready   = ($urandom_range(0, 9) < 6);
      clr_overrun = ($urandom_range(0, 19) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      if (par_valid && par_ready && !rst) begin
        exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_checks++; if (par_out !== exp_w) begin n_fail++; $display("FAIL rand_accept[%0d]: got %b exp %b", i, par_out, exp_w); end
      end
      step();
      exp_vec = {m_pv, (m_bits.size() != 0), CNT_W'(m_bits.size()), m_ovr, m_po};
      n_checks++; if ({par_valid, busy, bit_cnt, overrun, par_out} !== exp_vec) begin n_fail++; $display("FAIL rand_state[%0d]: got pv=%b busy=%b cnt=%0d ovr=%b po=%b exp %b", i, par_valid, busy, bit_cnt, overrun, par_out, exp_vec); end
    end
    rst = 1'b0;
    ser_valid = 1'b0;
    frame_start = 1'b0;
    clr_overrun = 1'b0;
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_dir_toggle();
    test_overrun();
    test_frame_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
